// File: rtl/fifo_vr.sv
// fifo_vr -- flip-flop FIFO with valid/ready handshakes on both sides.
//
// Works for any DEPTH >= 2, including non-power-of-two depths. Pointers wrap
// explicitly at DEPTH-1, so there is no power-of-two assumption.
// The read port is show-ahead: rd_data always presents the head-of-queue
// word, taken combinationally from registered storage.
//
// Optional feature (compile-time macro FIFO_BYPASS_EN):
//   When the FIFO is empty and wr_valid is high, the incoming word is
//   presented on the read port in the same cycle. If the consumer takes it,
//   it is never stored. This adds a combinational wr_data -> rd_data path.
//   Without the macro, a written word becomes visible one cycle after it is
//   written.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   wr_valid      in   producer has a word on wr_data
//   wr_ready      out  FIFO accepts a word this cycle (~full & ~rst)
//   wr_data       in   write word, WIDTH bits
//   rd_valid      out  rd_data holds the oldest word
//   rd_ready      in   consumer takes rd_data this cycle
//   rd_data       out  head-of-queue word, '0 when rd_valid is low
//   level         out  number of stored words
//   almost_full   out  level >= AF_THRESH
//   almost_empty  out  level <= AE_THRESH

module fifo_vr #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 10,
  parameter int AF_THRESH = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;

  logic full;
  logic not_empty;
  logic wr_fire;
  logic pass_through;
  logic store;
  logic pop;

  assign full      = (level_q == LW'(DEPTH));
  assign not_empty = (level_q != '0);
  assign wr_ready  = ~full & ~rst;
  assign wr_fire   = wr_valid & wr_ready;

`ifdef FIFO_BYPASS_EN
  logic bypass;

  // Bypass is only offered when the write would be accepted, so nothing is
  // presented on the read side while the FIFO is being reset.
  assign bypass       = wr_fire & ~not_empty;
  assign pass_through = bypass & rd_ready;
  assign rd_valid     = not_empty | bypass;

  always_comb begin
    rd_data = '0;
    if (not_empty) begin
      rd_data = mem[rd_ptr];
    end else if (bypass) begin
      rd_data = wr_data;
    end
  end
`else
  assign pass_through = 1'b0;
  assign rd_valid     = not_empty;
  assign rd_data      = not_empty ? mem[rd_ptr] : '0;
`endif

  // A word consumed straight through the bypass neither fills nor drains
  // storage; a stored word can only be popped when storage is non-empty.
  assign store = wr_fire & ~pass_through;
  assign pop   = rd_ready & not_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (store) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({store, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign level        = level_q;
  assign almost_full  = (level_q >= LW'(AF_THRESH));
  assign almost_empty = (level_q <= LW'(AE_THRESH));

endmodule

// File: tb/tb_fifo_vr.sv
module tb_fifo_vr;

  localparam int W  = 32;
  localparam int D  = 10;
  localparam int AF = 8;
  localparam int AE = 2;
  localparam int LW = $clog2(D + 1);

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;

  fifo_vr #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a plain queue.
  logic [W-1:0] model_q[$];
  bit           model_ok = 1'b0;
  // Words the DUT actually handed over on a read handshake.
  logic [W-1:0] got[$];

`ifdef FIFO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the queue model.
  always @(negedge clk) begin
    if (model_ok) begin
      if (rst) begin
        chk("wr_ready_in_rst", {63'd0, wr_ready}, 64'd0);
      end else begin
        int           n;
        bit           byp;
        logic         e_rv;
        logic [W-1:0] e_rd;
        n    = model_q.size();
        byp  = BYPASS && (n == 0) && wr_valid;
        e_rv = (n != 0) || byp;
        e_rd = '0;
        if (n != 0) e_rd = model_q[0];
        else if (byp) e_rd = wr_data;
        chk("wr_ready",     {63'd0, wr_ready},     {63'd0, (n < D)});
        chk("rd_valid",     {63'd0, rd_valid},     {63'd0, e_rv});
        chk("rd_data",      {32'd0, rd_data},      {32'd0, e_rd});
        chk("level",        {60'd0, level},        64'(n));
        chk("almost_full",  {63'd0, almost_full},  {63'd0, (n >= AF)});
        chk("almost_empty", {63'd0, almost_empty}, {63'd0, (n <= AE)});
      end
    end
  end

  // One clock cycle: drive inputs, let the compare process look at the
  // negative edge, then advance the model across the rising edge.
  task automatic cyc(input logic r, input logic wv, input logic [W-1:0] wd, input logic rr);
    int n;
    rst      = r;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(negedge clk);
    if (!r && rd_valid && rr) got.push_back(rd_data);
    @(posedge clk);
    n = model_q.size();
    if (r) begin
      model_q.delete();
      model_ok = 1'b1;
    end else if (BYPASS && n == 0 && wv && rr) begin
      // passes straight through, nothing stored
    end else begin
      if (rr && n != 0) void'(model_q.pop_front());
      if (wv && n < D) model_q.push_back(wd);
    end
    #1;
  endtask

  task automatic idle();
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;

    // 1: reset then idle
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    idle();
    chk("t1_level",    {60'd0, level},        64'd0);
    chk("t1_rd_valid", {63'd0, rd_valid},     64'd0);
    chk("t1_rd_data",  {32'd0, rd_data},      64'd0);
    chk("t1_wr_ready", {63'd0, wr_ready},     64'd1);
    chk("t1_ae",       {63'd0, almost_empty}, 64'd1);
    chk("t1_af",       {63'd0, almost_full},  64'd0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // 2: fill with 0x00..0x09, then an 11th write is refused
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, W'(i), 1'b0);
    idle();
    chk("t2_level",    {60'd0, level},       64'd10);
    chk("t2_wr_ready", {63'd0, wr_ready},    64'd0);
    chk("t2_af",       {63'd0, almost_full}, 64'd1);
    cyc(1'b0, 1'b1, 32'hEE, 1'b0);
    idle();
    chk("t2_level_after_11th", {60'd0, level}, 64'd10);

    // 3: drain in order
    got.delete();
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("t3_count",    64'(got.size()),  64'd10);
    for (int i = 0; i < got.size(); i++) chk("t3_order", {32'd0, got[i]}, 64'(i));
    chk("t3_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("t3_level",    {60'd0, level},    64'd0);

    // 4: level 5, 20 cycles of simultaneous write+read
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, W'(32'h10 + i), 1'b0);
    got.delete();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, W'(32'h20 + i), 1'b1);
    idle();
    chk("t4_level", {60'd0, level},   64'd5);
    chk("t4_count", 64'(got.size()),  64'd20);
    for (int i = 0; i < got.size(); i++)
      chk("t4_order", {32'd0, got[i]}, (i < 5) ? 64'(32'h10 + i) : 64'(32'h20 + i - 5));
    chk("t4_head", {32'd0, rd_data}, 64'h2F);

    // 5: reset at level 7, then reuse
    cyc(1'b0, 1'b1, 32'h60, 1'b0);
    cyc(1'b0, 1'b1, 32'h61, 1'b0);
    idle();
    chk("t5_level7", {60'd0, level}, 64'd7);
    cyc(1'b1, 1'b1, 32'h62, 1'b1);
    idle();
    chk("t5_level",    {60'd0, level},    64'd0);
    chk("t5_rd_valid", {63'd0, rd_valid}, 64'd0);
    cyc(1'b0, 1'b1, 32'hAB, 1'b0);
    idle();
    chk("t5_readback", {32'd0, rd_data}, 64'hAB);
    chk("t5_level1",   {60'd0, level},   64'd1);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // 6: empty, write 0x5A with rd_ready high
    rst = 1'b0; wr_valid = 1'b1; wr_data = 32'h5A; rd_ready = 1'b1;
    #1;
    chk("t6_rd_valid_same", {63'd0, rd_valid}, BYPASS ? 64'd1 : 64'd0);
    chk("t6_rd_data_same",  {32'd0, rd_data},  BYPASS ? 64'h5A : 64'd0);
    cyc(1'b0, 1'b1, 32'h5A, 1'b1);
    idle();
    chk("t6_level_next",   {60'd0, level},   BYPASS ? 64'd0 : 64'd1);
    chk("t6_rd_data_next", {32'd0, rd_data}, BYPASS ? 64'd0 : 64'h5A);
    cyc(1'b0, 1'b0, '0, 1'b1);

    // mixed traffic: reaches full, then reads fire while writes are refused
    for (int i = 0; i < 40; i++)
      cyc(1'b0, (i % 3) != 0, W'(32'h100 + i), (i > 20) && ((i % 4) == 0));
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, W'(32'h200 + i), 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("mix_drained", {60'd0, level}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
